// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_chain
// Purpose  : Parametrised control pipeline with per-stage valid, stall, flush
//            and register read-after-write interlock with bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_chain #(
    parameter int             OPW    = 8,
    parameter int             ORW    = 8,
    parameter int             PCW    = 8,
    parameter int             RAW    = 3,
    parameter int             STAGES = 3,
    parameter logic [OPW-1:0] NOP    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPW+ORW-1:0]   segment,
    input  logic [PCW-1:0]       pc_in,
    input  logic                 fl_in,
    input  logic                 in_reads,
    input  logic                 in_writes,
    input  logic                 ex_stall,
    input  logic                 flush,
    output logic [RAW-1:0]       read_address,
    output logic [OPW-1:0]       opcode_o,
    output logic [ORW-1:0]       or_o,
    output logic [PCW-1:0]       npc_o,
    output logic                 fl_o,
    output logic                 valid_o,
    output logic [RAW-1:0]       write_address,
    output logic                 hazard_o,
    output logic [15:0]          bubble_cnt
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]          valid_q, valid_d;
    logic [STAGES-1:0]          fl_q, fl_d;
    logic [STAGES-1:0]          rd_q, rd_d;
    logic [STAGES-1:0]          wr_q, wr_d;
    logic [STAGES-1:0][OPW-1:0] op_q, op_d;
    logic [STAGES-1:0][ORW-1:0] opr_q, opr_d;
    logic [STAGES-1:0][PCW-1:0] npc_q, npc_d;
    logic [15:0]                cnt_q, cnt_d;

    logic                       w_match;
    logic                       w_hazard;

    // Only valid writers in stages 1..LAST can block the reader in stage 0.
    always_comb begin
        w_match = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (valid_q[k] && wr_q[k] && (op_q[k][RAW-1:0] == op_q[0][RAW-1:0])) begin
                w_match = 1'b1;
            end
        end
        w_hazard = valid_q[0] && rd_q[0] && w_match && !ex_stall && !flush;
    end

    always_comb begin
        valid_d = valid_q;
        fl_d    = fl_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        op_d    = op_q;
        opr_d   = opr_q;
        npc_d   = npc_q;
        cnt_d   = cnt_q;

        if (flush) begin
            valid_d = '0;
            fl_d    = '0;
            rd_d    = '0;
            wr_d    = '0;
            opr_d   = '0;
            npc_d   = '0;
            for (int k = 0; k < STAGES; k++) begin
                op_d[k] = NOP;
            end
        end else if (ex_stall) begin
            // whole pipe holds: defaults already cover it
        end else if (w_hazard) begin
            for (int k = 2; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                fl_d[k]    = fl_q[k-1];
                rd_d[k]    = rd_q[k-1];
                wr_d[k]    = wr_q[k-1];
                op_d[k]    = op_q[k-1];
                opr_d[k]   = opr_q[k-1];
                npc_d[k]   = npc_q[k-1];
            end
            valid_d[1] = 1'b0;
            fl_d[1]    = 1'b0;
            rd_d[1]    = 1'b0;
            wr_d[1]    = 1'b0;
            op_d[1]    = NOP;
            opr_d[1]   = '0;
            npc_d[1]   = '0;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                fl_d[k]    = fl_q[k-1];
                rd_d[k]    = rd_q[k-1];
                wr_d[k]    = wr_q[k-1];
                op_d[k]    = op_q[k-1];
                opr_d[k]   = opr_q[k-1];
                npc_d[k]   = npc_q[k-1];
            end
            if (in_valid) begin
                valid_d[0] = 1'b1;
                fl_d[0]    = fl_in;
                rd_d[0]    = in_reads;
                wr_d[0]    = in_writes;
                op_d[0]    = segment[OPW+ORW-1:ORW];
                opr_d[0]   = segment[ORW-1:0];
                npc_d[0]   = pc_in;
            end else begin
                valid_d[0] = 1'b0;
                fl_d[0]    = 1'b0;
                rd_d[0]    = 1'b0;
                wr_d[0]    = 1'b0;
                op_d[0]    = NOP;
                opr_d[0]   = '0;
                npc_d[0]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            fl_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            op_q    <= {STAGES{NOP}};
            opr_q   <= '0;
            npc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            fl_q    <= fl_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            op_q    <= op_d;
            opr_q   <= opr_d;
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready      = !ex_stall && !w_hazard && !flush;
    assign hazard_o      = w_hazard;
    assign read_address  = op_q[0][RAW-1:0];
    assign opcode_o      = op_q[LAST];
    assign or_o          = opr_q[LAST];
    assign npc_o         = npc_q[LAST];
    assign fl_o          = fl_q[LAST];
    assign valid_o       = valid_q[LAST];
    assign write_address = op_q[LAST][RAW-1:0];
    assign bubble_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
- Parametrised control pipeline for the RNBIP-class processor.
- Carries opcode, operand byte, next-PC and flag through STAGES register stages, like the fixed fetch/decode/execute chain.
- Adds a valid bit per stage, downstream stall, branch flush, and register read-after-write hazard interlock with bubble insertion.
- Sits between instruction fetch and the execute-stage control decoder.

Parameters:
OPW, 8, opcode width
ORW, 8, operand width
PCW, 8, program-counter width
RAW, 3, register address width; address is opcode[RAW-1:0]
STAGES, 3, number of pipeline stages, legal range 2..8
NOP, 0, opcode value inserted for bubbles and flush

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  instruction accepted this edge when in_valid && in_ready
segment  in  OPW+ORW  {opcode, operand}
pc_in  in  PCW  next-PC of offered instruction
fl_in  in  1  flag-check bit of offered instruction
in_reads  in  1  offered instruction reads register opcode[RAW-1:0]
in_writes  in  1  offered instruction writes register opcode[RAW-1:0]
ex_stall  in  1  downstream hold; whole pipe freezes
flush  in  1  taken branch/call/return; kill all in-flight instructions
read_address  out  RAW  opcode[RAW-1:0] of stage 0, combinational
opcode_o  out  OPW  last-stage opcode
or_o  out  ORW  last-stage operand
npc_o  out  PCW  last-stage next-PC
fl_o  out  1  last-stage flag-check bit
valid_o  out  1  last-stage valid
write_address  out  RAW  last-stage opcode[RAW-1:0]
hazard_o  out  1  interlock active this cycle
bubble_cnt  out  16  count of hazard bubbles, saturating

Behaviour:
- Reset (rst_n low, asynchronous), every stage: valid=0, opcode=NOP, operand=0, npc=0, flag=0, reads=0, writes=0. bubble_cnt=0.
- Each stage register holds {valid, opcode, operand, npc, flag, reads, writes}. Stage 0 loads from the inputs; stage k loads from stage k-1.
- Outputs come from stage STAGES-1. An instruction accepted at edge t reaches the outputs at edge t+STAGES-1 when there is no stall or hazard.
- hazard (combinational), all of the following true:
  - stage0.valid and stage0.reads;
  - some stage k in 1..STAGES-1 has valid, writes, and opcode[RAW-1:0] == stage0.opcode[RAW-1:0];
  - ex_stall=0 and flush=0.
- hazard_o = hazard.
- in_ready = !ex_stall && !hazard && !flush.
- Per-edge priority, highest first:
  1. flush: all stages are cleared to the reset bubble value (valid=0, opcode=NOP). The offered input is not accepted. bubble_cnt is unchanged.
  2. ex_stall: all stages hold their values. No accept.
  3. hazard: stage 0 holds; stage 1 loads a bubble (valid=0, opcode=NOP); stages 2..STAGES-1 advance; bubble_cnt increments. No accept.
  4. Normal: all stages shift. Stage 0 loads the inputs with valid=in_valid. If in_valid=0, stage 0 becomes a bubble with opcode=NOP.
- bubble_cnt saturates at 16'hFFFF.
- Invalid stages never trigger a hazard, whatever their opcode bits are.
- write_address reflects the last-stage opcode even when that stage is invalid; the consumer qualifies it with valid_o.
- STAGES=2: the hazard compare covers stage 1 only.
- Reset asserted mid-stall or mid-hazard: the pipe empties immediately. The first accept is at the first edge after rst_n rises with in_valid=1.

Test Plan:
- Reset then stream (STAGES=3): opcodes 8'h41, 8'h59, 8'h81 offered on consecutive cycles, no hazard flags → opcode_o=41 and valid_o=1 two edges after its accept, then 59, then 81; in_ready stays 1.
- RAW hazard: accept 8'h5A (MVI r2, writes=1), next offer 8'h82 (ADA r2, reads=1) → hazard_o=1 for 2 cycles, two bubbles reach the output (valid_o=0, opcode_o=00), bubble_cnt=2, then 82 proceeds.
- Flush: pipe full with 41/42/43, flush=1 for one cycle with in_valid=1 → after that edge all valid=0 and opcode_o=00; the offered instruction is dropped; the next offer is accepted normally.
- ex_stall: hold for 3 cycles with the pipe full → outputs unchanged, in_ready=0, bubble_cnt unchanged; release → shifting resumes with no lost or duplicated instruction.
- Priority: flush=1, ex_stall=1 and a hazard pending in the same cycle → flush wins; all stages cleared, bubble_cnt unchanged.
- Async reset mid-hazard: drop rst_n between clock edges → outputs go to reset values immediately and bubble_cnt=0. Separately, force bubble_cnt to 16'hFFFF plus one more hazard → it stays at FFFF.
